// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bus between the UART receiver / consumer side and the receive FIFO.
//   rx_done, rx_data   : receiver Done strobe and Received_DATA word
//   rd_en, ovr_clear   : consumer read request and overrun-flag clear
//   rd_data, rd_valid  : registered read word and its one-cycle valid pulse
//   empty, full, count : fill status (count is 0..DEPTH)
//   overrun            : sticky "word dropped while full" flag
// master = receiver/consumer side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 8
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic                  rx_done;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rd_en;
   logic                  ovr_clear;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  full;
   logic [ADDR_W:0]       count;
   logic                  overrun;

   modport master (
      output rx_done, rx_data, rd_en, ovr_clear,
      input  rd_data, rd_valid, empty, full, count, overrun
   );

   modport slave (
      input  rx_done, rx_data, rd_en, ovr_clear,
      output rd_data, rd_valid, empty, full, count, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Each rising edge of rx_done queues
// rx_data into a circular FIFO; the consumer drains it with rd_en and gets the
// word one cycle later on rd_data with a rd_valid pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_rx_fifo_if.slave (rx_done/rx_data in, rd_en/ovr_clear in,
//          rd_data/rd_valid/empty/full/count/overrun out)
// DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int unsigned  DATA_WIDTH = 16,
   parameter int unsigned  DEPTH      = 8,
   localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           rst,
   uart_rx_fifo_if.slave bus
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  done_q;
   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]       count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overrun_q, overrun_d;

   logic empty, full;
   logic wr_req, rd_ok, wr_ok, wr_drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

   // One request per Done rising edge; done_q resets high so a Done held
   // through reset release is not mistaken for a new word.
   assign wr_req  = bus.rx_done & ~done_q;
   assign rd_ok   = bus.rd_en & ~empty;
   // A read in the same cycle frees a slot, so a write into a full FIFO is
   // still accepted then.
   assign wr_ok   = wr_req & (~full | rd_ok);
   assign wr_drop = wr_req & full & ~rd_ok;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overrun_d  = overrun_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      if (rd_ok) begin
         rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
         rd_data_d  = mem[rd_ptr_q];
         rd_valid_d = 1'b1;
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      // Set has priority over clear.
      if (wr_drop) begin
         overrun_d = 1'b1;
      end else if (bus.ovr_clear) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q     <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         done_q     <= bus.rx_done;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   // Storage needs no reset; only pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= bus.rx_data;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count    = count_q;
   assign bus.overrun  = overrun_q;

endmodule
